// File: rtl/pingpong_buf_scheduler.sv
// Raster timing plus ping-pong line-buffer sequencer: host writes fill one buffer
// while the other drains through the frame mux during active video.
module pingpong_buf_scheduler #(
  parameter int PX_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PX_W-1:0] HBOut,
  input  logic [PX_W-1:0] VBOut,
  input  logic [PX_W-1:0] AIPOut,
  input  logic [PX_W-1:0] AILOut,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic            WE0,
  output logic            WE1,
  output logic            RE0,
  output logic            RE1,
  output logic            IncAddr0,
  output logic            IncAddr1,
  output logic            ResetAddr0,
  output logic            ResetAddr1,
  output logic            SelBuf0,
  output logic            SelBuf1,
  output logic            SelBlank,
  output logic            IncPx,
  output logic            ResetPx,
  output logic            IncLine,
  output logic            ResetLine,
  output logic            SyncHB,
  output logic            SyncVB,
  output logic            Buf0Empty,
  output logic            Buf1Empty,
  output logic            underrun,
  output logic [5:0]      dbg_state
);

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'd0,
    BUF_FILLING  = 2'd1,
    BUF_FULL     = 2'd2,
    BUF_DRAINING = 2'd3
  } buf_state_t;

  localparam logic [PX_W:0] ONE_W = 1;

  logic [PX_W-1:0] px, line, wc;
  logic [PX_W-1:0] cfg_hb, cfg_vb, cfg_aip, cfg_ail;
  logic            fp, rp;
  buf_state_t      buf_st [2];

  logic [PX_W:0] lt_sum, ft_sum, lt, ft;
  logic          line_end, frame_end, active;
  buf_state_t    fill_st, drain_st;
  logic          accept, wr_last, rd_first, rd_last, go;
  logic [1:0]    we, re, sel, inc_addr, rst_addr;

  assign lt_sum = {1'b0, cfg_aip} + {1'b0, cfg_hb};
  assign ft_sum = {1'b0, cfg_ail} + {1'b0, cfg_vb};
  assign lt     = (lt_sum == '0) ? ONE_W : lt_sum;
  assign ft     = (ft_sum == '0) ? ONE_W : ft_sum;

  assign line_end  = ({1'b0, px} == (lt - ONE_W));
  assign frame_end = line_end && ({1'b0, line} == (ft - ONE_W));
  assign active    = (px < cfg_aip) && (line < cfg_ail);

  assign fill_st  = buf_st[fp];
  assign drain_st = buf_st[rp];

  // Handshake: a word transfers in any cycle where wr_valid && wr_ready; wr_ready
  // depends only on registered state, and WE/address strobes follow the transfer.
  assign wr_ready = (cfg_aip != '0) && ((fill_st == BUF_EMPTY) || (fill_st == BUF_FILLING));
  assign accept   = wr_valid && wr_ready;
  // >= rather than == keeps a buffer from never completing if AIP shrinks mid-fill.
  assign wr_last  = (({1'b0, wc} + ONE_W) >= {1'b0, cfg_aip});

  assign rd_first = (px == '0);
  assign rd_last  = (({1'b0, px} + ONE_W) == {1'b0, cfg_aip});
  assign go       = active && ((drain_st == BUF_DRAINING) || (rd_first && (drain_st == BUF_FULL)));

  // Fill and drain always target different buffers, so the two paths never collide.
  always_comb begin
    we       = 2'b00;
    re       = 2'b00;
    sel      = 2'b00;
    inc_addr = 2'b00;
    rst_addr = 2'b00;
    if (accept) begin
      we[fp] = 1'b1;
      if (wr_last) rst_addr[fp] = 1'b1;
      else         inc_addr[fp] = 1'b1;
    end
    if (go) begin
      re[rp]  = 1'b1;
      sel[rp] = 1'b1;
      if (rd_last) rst_addr[rp] = 1'b1;
      else         inc_addr[rp] = 1'b1;
    end
  end

  assign WE0        = we[0];
  assign WE1        = we[1];
  assign RE0        = re[0];
  assign RE1        = re[1];
  assign SelBuf0    = sel[0];
  assign SelBuf1    = sel[1];
  assign SelBlank   = !go;
  assign IncAddr0   = inc_addr[0];
  assign IncAddr1   = inc_addr[1];
  assign ResetAddr0 = rst_addr[0];
  assign ResetAddr1 = rst_addr[1];

  assign IncPx     = !line_end;
  assign ResetPx   = line_end;
  assign IncLine   = line_end && !frame_end;
  assign ResetLine = frame_end;
  assign SyncHB    = (px >= cfg_aip);
  assign SyncVB    = (line >= cfg_ail);
  assign Buf0Empty = (buf_st[0] == BUF_EMPTY);
  assign Buf1Empty = (buf_st[1] == BUF_EMPTY);
  assign dbg_state = {buf_st[1], buf_st[0], rp, fp};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px        <= '0;
      line      <= '0;
      wc        <= '0;
      cfg_hb    <= '0;
      cfg_vb    <= '0;
      cfg_aip   <= '0;
      cfg_ail   <= '0;
      fp        <= 1'b0;
      rp        <= 1'b0;
      buf_st[0] <= BUF_EMPTY;
      buf_st[1] <= BUF_EMPTY;
      underrun  <= 1'b0;
    end else begin
      px <= line_end ? '0 : px + 1'b1;
      if (frame_end)     line <= '0;
      else if (line_end) line <= line + 1'b1;

      // Timing config only changes on a frame boundary.
      if (frame_end) begin
        cfg_hb  <= HBOut;
        cfg_vb  <= VBOut;
        cfg_aip <= AIPOut;
        cfg_ail <= AILOut;
      end

      if (accept) begin
        if (wr_last) begin
          wc         <= '0;
          buf_st[fp] <= BUF_FULL;
          fp         <= !fp;
        end else begin
          wc         <= wc + 1'b1;
          buf_st[fp] <= BUF_FILLING;
        end
      end

      if (go) begin
        if (rd_last) begin
          buf_st[rp] <= BUF_EMPTY;
          rp         <= !rp;
        end else if (rd_first) begin
          buf_st[rp] <= BUF_DRAINING;
        end
      end

      if (active && rd_first && (drain_st != BUF_FULL) && (drain_st != BUF_DRAINING))
        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_buf_scheduler.sv
// Directed bench for pingpong_buf_scheduler: reset, raster strobes, fill, ping-pong
// drain with backpressure, and frame-boundary config change.
module tb_pingpong_buf_scheduler;
  localparam int PX_W = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [PX_W-1:0] HBOut, VBOut, AIPOut, AILOut;
  logic            wr_valid;
  logic            wr_ready, WE0, WE1, RE0, RE1;
  logic            IncAddr0, IncAddr1, ResetAddr0, ResetAddr1;
  logic            SelBuf0, SelBuf1, SelBlank;
  logic            IncPx, ResetPx, IncLine, ResetLine;
  logic            SyncHB, SyncVB, Buf0Empty, Buf1Empty, underrun;
  logic [5:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  pingpong_buf_scheduler #(.PX_W(PX_W)) dut (
    .clk(clk), .reset(reset),
    .HBOut(HBOut), .VBOut(VBOut), .AIPOut(AIPOut), .AILOut(AILOut),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .WE0(WE0), .WE1(WE1), .RE0(RE0), .RE1(RE1),
    .IncAddr0(IncAddr0), .IncAddr1(IncAddr1),
    .ResetAddr0(ResetAddr0), .ResetAddr1(ResetAddr1),
    .SelBuf0(SelBuf0), .SelBuf1(SelBuf1), .SelBlank(SelBlank),
    .IncPx(IncPx), .ResetPx(ResetPx), .IncLine(IncLine), .ResetLine(ResetLine),
    .SyncHB(SyncHB), .SyncVB(SyncVB),
    .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty),
    .underrun(underrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  wire [20:0] obs_all = {wr_ready, WE0, WE1, RE0, RE1,
                         IncAddr0, IncAddr1, ResetAddr0, ResetAddr1,
                         SelBuf0, SelBuf1, SelBlank,
                         IncPx, ResetPx, IncLine, ResetLine,
                         SyncHB, SyncVB, Buf0Empty, Buf1Empty, underrun};
  wire [14:0] obs_pp = {wr_ready, WE0, WE1, RE0, RE1, SelBuf0, SelBuf1, SelBlank,
                        IncAddr0, IncAddr1, ResetAddr0, ResetAddr1,
                        Buf0Empty, Buf1Empty, underrun};
  wire [7:0]  obs_raster = {SelBlank, SyncHB, SyncVB, IncPx, ResetPx, IncLine, ResetLine, underrun};

  localparam logic [20:0] RESET_VEC = 21'b0_0000_0000_001_0101_11_11_0;

  logic [14:0] pp_exp [18];

  // Leaves the bench at a falling edge with cfg loaded and px=0, line=0.
  task automatic do_reset(input int aip, input int hb, input int ail, input int vb);
    @(negedge clk);
    reset    = 1'b0;
    wr_valid = 1'b0;
    AIPOut   = aip[PX_W-1:0];
    HBOut    = hb[PX_W-1:0];
    AILOut   = ail[PX_W-1:0];
    VBOut    = vb[PX_W-1:0];
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (obs_all !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_poweron got=%b want=%b", obs_all, RESET_VEC);
    end
    do_reset(4, 2, 2, 1);
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs_all !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_midframe got=%b want=%b", obs_all, RESET_VEC);
    end
    total++;
    if (dbg_state !== 6'd0) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", dbg_state, 6'd0);
    end
    wr_valid = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic test_underrun;
    logic [7:0] exp_v;
    do_reset(4, 2, 2, 1);
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 6; p++) begin
        if (l != 0 || p != 0) @(negedge clk);
        #1;
        exp_v = {1'b1, (p >= 4), (l >= 2), (p != 5), (p == 5),
                 (p == 5 && l != 2), (p == 5 && l == 2), !(l == 0 && p == 0)};
        total++;
        if (obs_raster !== exp_v) begin
          bad++;
          $display("FAIL raster l=%0d p=%0d got=%b want=%b", l, p, obs_raster, exp_v);
        end
      end
    end
  endtask

  task automatic test_fill;
    logic [4:0] exp_v;
    do_reset(4, 2, 2, 1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      wr_valid = 1'b1;
      #1;
      exp_v = {1'b1, 1'b1, 1'b0, (k < 3), (k == 3)};
      total++;
      if ({wr_ready, WE0, WE1, IncAddr0, ResetAddr0} !== exp_v) begin
        bad++;
        $display("FAIL fill k=%0d got=%b want=%b", k,
                 {wr_ready, WE0, WE1, IncAddr0, ResetAddr0}, exp_v);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    total++;
    if ({Buf0Empty, Buf1Empty, wr_ready, WE1} !== 4'b0110) begin
      bad++;
      $display("FAIL fill_done got=%b want=%b", {Buf0Empty, Buf1Empty, wr_ready, WE1}, 4'b0110);
    end
    wr_valid = 1'b1;
    #1;
    total++;
    if ({WE0, WE1, IncAddr1, ResetAddr1} !== 4'b0110) begin
      bad++;
      $display("FAIL fill_buf1 got=%b want=%b", {WE0, WE1, IncAddr1, ResetAddr1}, 4'b0110);
    end
    wr_valid = 1'b0;
  endtask

  // AIL starts at 0 so both buffers fill without an underrun; AIL=2 loads at the
  // first frame end (px=5), then lines 0 and 1 drain buf0 and buf1.
  task automatic test_back_to_back;
    pp_exp = '{
      15'b110_00_001_1000_11_0, 15'b110_00_001_1000_01_0, 15'b110_00_001_1000_01_0,
      15'b110_00_001_0010_01_0, 15'b101_00_001_0100_01_0, 15'b101_00_001_0100_00_0,
      15'b101_10_100_1100_00_0, 15'b101_10_100_1001_00_0, 15'b000_10_100_1000_00_0,
      15'b000_10_100_0010_00_0, 15'b100_00_001_0000_10_0, 15'b100_00_001_0000_10_0,
      15'b100_01_010_0100_10_0, 15'b100_01_010_0100_10_0, 15'b100_01_010_0100_10_0,
      15'b100_01_010_0001_10_0, 15'b100_00_001_0000_11_0, 15'b100_00_001_0000_11_0};
    do_reset(4, 2, 0, 1);
    AILOut = 10'd2;
    for (int t = 0; t < 18; t++) begin
      if (t != 0) @(negedge clk);
      wr_valid = (t < 10);
      #1;
      total++;
      if (obs_pp !== pp_exp[t]) begin
        bad++;
        $display("FAIL pingpong t=%0d got=%b want=%b", t, obs_pp, pp_exp[t]);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_config_change;
    logic exp_rp;
    do_reset(4, 2, 2, 1);
    AIPOut = 10'd8;
    for (int t = 0; t < 28; t++) begin
      if (t != 0) @(negedge clk);
      #1;
      exp_rp = (t == 5) || (t == 11) || (t == 17) || (t == 27);
      total++;
      if (ResetPx !== exp_rp) begin
        bad++;
        $display("FAIL cfg_resetpx t=%0d got=%b want=%b", t, ResetPx, exp_rp);
      end
      if (t == 4) begin
        total++;
        if (SyncHB !== 1'b1) begin
          bad++;
          $display("FAIL cfg_synchb_old got=%b want=1", SyncHB);
        end
      end
      if (t == 22) begin
        total++;
        if (SyncHB !== 1'b0) begin
          bad++;
          $display("FAIL cfg_synchb_new got=%b want=0", SyncHB);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    HBOut    = '0;
    VBOut    = '0;
    AIPOut   = '0;
    AILOut   = '0;
    test_reset();
    test_underrun();
    test_fill();
    test_back_to_back();
    test_config_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pingpong_buf_scheduler.md
# pingpong_buf_scheduler

Raster and ping-pong sequencer for the display datapath's two line buffers (Buf0/Buf1). It generates the pixel/line strobes and blanking syncs. It admits host pixel writes into whichever buffer is filling, and drains the full buffer through the frame mux during active video. It drives the same control nets the datapath consumes: WE/RE, IncAddr/ResetAddr, SelBuf0/SelBuf1/SelBlank, IncPx/ResetPx, IncLine/ResetLine.

## Interface
- PX_W, 10, width of timing config inputs and internal counters
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- HBOut, VBOut, AIPOut, AILOut  in  PX_W each  horizontal blank px, vertical blank lines, active px/line, active lines
- wr_valid  in  1  host offers one pixel word (WData handled in datapath)
- wr_ready  out  1  scheduler can accept a word this cycle
- WE0, WE1, RE0, RE1  out  1 each  buffer write/read enables
- IncAddr0, IncAddr1, ResetAddr0, ResetAddr1  out  1 each  address counter controls; Reset has priority in the counter
- SelBuf0, SelBuf1, SelBlank  out  1 each  frame mux select, exactly one high
- IncPx, ResetPx, IncLine, ResetLine  out  1 each  mirror strobes for external counters
- SyncHB, SyncVB  out  1 each  horizontal/vertical blank indicators
- Buf0Empty, Buf1Empty  out  1 each  buffer in EMPTY state
- underrun  out  1  sticky: an active line found no FULL buffer

## Operation
- Config regs (cfg_*) reset to 0. They load from inputs in any cycle where frame_end=1.
- LT = max(AIP+HB,1), FT = max(AIL+VB,1); sums are PX_W+1 bits.
- px counts 0..LT-1; line counts 0..FT-1.
- line_end = (px==LT-1); frame_end = line_end && (line==FT-1). With zero config, frame_end is true every cycle.
- Per cycle: IncPx=!line_end, ResetPx=line_end; IncLine=line_end&&!frame_end, ResetLine=frame_end.
- active = (px<AIP) && (line<AIL); SyncHB = px>=AIP; SyncVB = line>=AIL.
- Each buffer has a state: EMPTY, FILLING, FULL, DRAINING. Also kept: fill pointer fp, read pointer rp, write count wc.
- Write path:
  - wr_ready = (AIP!=0) && buf[fp] in {EMPTY, FILLING}.
  - Accept = wr_valid && wr_ready; WE[fp] = accept (combinational from wr_valid).
  - On accept with wc<AIP-1: IncAddr[fp], wc++, buf[fp] goes to FILLING.
  - On accept with wc==AIP-1: ResetAddr[fp] instead of IncAddr, wc=0, buf[fp] goes to FULL, fp toggles.
- Read path:
  - go = active && (buf[rp]==DRAINING || (px==0 && buf[rp]==FULL)).
  - When go: RE[rp]=1, SelBuf[rp]=1; IncAddr[rp], except at px==AIP-1 where ResetAddr[rp] is asserted instead.
  - At px==0 with go: buf[rp] goes to DRAINING.
  - At px==AIP-1 with go: buf[rp] goes to EMPTY and rp toggles.
  - AIP==1: FULL goes straight to EMPTY in one cycle.
  - When !go: SelBlank=1.
  - active && px==0 && buf[rp]!=FULL && buf[rp]!=DRAINING: set underrun. The whole line is blank and rp does not move.
- A buffer is never filling and draining at once, so the address counter is never driven by both paths.
- A buffer freed (goes to EMPTY) in cycle N raises wr_ready from cycle N+1 if fp points to it. No same-cycle bypass.
- A config change mid-frame takes effect only at the next frame_end. A line being drained completes using the old cfg.

## Timing
- Reset values: px=line=0, cfg=0, both buffers EMPTY, fp=rp=0, wc=0, underrun=0.
- Outputs during reset: SelBlank=1, SyncHB=1, SyncVB=1, Buf0Empty=Buf1Empty=1, ResetPx=ResetLine=1; all other outputs 0, including wr_ready.
- All outputs are decodes of registered state. The only combinational input→output path is wr_valid→WE/IncAddr/ResetAddr.
- Write latency: a word accepted in cycle N is written at edge N+1. After the last word, BufxEmpty and FULL are visible at N+1.
- Read: RE and SelBuf are high in the same cycle the px counter shows the pixel; the datapath registers the data.
- Reset mid-fill or mid-drain abandons the buffer contents. All state returns to reset values.

## Test plan
- Reset: assert reset mid-frame → every output at its listed reset value within the same cycle.
- Fill, using AIP=4, HB=2, AIL=2, VB=1 (LT=6, FT=3):
  - Drive wr_valid=1 for 4 cycles → WE0 ×4, IncAddr0 ×3 then ResetAddr0, Buf0Empty=0.
  - fp moves to buf1; wr_ready stays 1.
- Underrun: same config, no writes → line 0 has SelBlank=1 for px 0–3 and underrun=1 from the next cycle. SyncHB=1 at px 4–5, SyncVB=1 on line 2.
- Steady ping-pong: writes keep both buffers full → lines 0 and 1 show RE0/SelBuf0 then RE1/SelBuf1 for px 0–3. Buf0Empty rises the cycle after px=3 of line 0; underrun stays 0.
- Backpressure: both buffers FULL → wr_ready=0. It rises exactly one cycle after buf0 finishes draining at px=3.
- Config change: write AIP=8 mid-frame → line timing keeps LT=6 until frame_end, then LT=10.
